div_shift_core: RTL and testbench
=================================

Name: div_shift_core

Overview:
- Datapath responder paired with the divider controller.
- Accepts the controller's ld/sl strobes and the packed {dividend, divisor} init_val.
- Runs an unsigned radix-2 restoring division, one quotient bit per sl cycle.
- Raises f_done once the quotient and remainder are final, so the controller can return to IDLE.

Parameters:
- WIDTH, default `WIDTH (32): operand, quotient and remainder width.
- CNT_W, default `WIDTH_LOG_2+1: iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ld  in  1  load strobe from the controller; captures init_val.
- sl  in  1  step enable from the controller; one iteration per cycle while high.
- init_val  in  2*WIDTH  {dividend[2W-1:W], divisor[W-1:0]}.
- f_done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  WIDTH  quotient register.
- remainder  out  WIDTH  remainder register.
- div_by_zero  out  1  high when the loaded divisor was 0; held until the next ld.

Behaviour:
- Reset (rst=0, async): quo, rem, dvsr, cnt, f_done, done, dz all 0; outputs read 0.
- Registers:
  - quo[W-1:0]: initially the dividend, becomes the quotient.
  - rem[W:0]: partial remainder.
  - dvsr[W-1:0].
  - cnt[CNT_W-1:0].
  - done: sticky.
  - dz.
- ld (priority over sl, honoured in any state, including mid-division):
  - quo <= dividend; rem <= 0; dvsr <= divisor; cnt <= 0; done <= 0; f_done <= 0.
  - dz <= (divisor == 0).
- Step, taken on a clk edge with sl=1, ld=0, done=0, dz=0:
  - trial = {rem[W-1:0], quo[W-1]} - {1'b0, dvsr}, computed W+1 bits wide.
  - If trial[W]==0: rem <= trial; quo <= {quo[W-2:0], 1}.
  - Otherwise: rem <= {rem[W-1:0], quo[W-1]}; quo <= {quo[W-2:0], 0}.
  - cnt <= cnt+1.
  - If cnt == WIDTH-1 (this is the last step): done <= 1 and f_done <= 1.
- Divide by zero, on the first clk edge with sl=1, ld=0, done=0, dz=1:
  - quo <= all ones; rem <= {1'b0, dividend}; done <= 1; f_done <= 1.
  - No iterations are run.
- f_done:
  - Registered; high for exactly one cycle, then cleared on the next edge.
- sl while done=1:
  - Ignored. The controller still drives sl=1 during the cycle it samples f_done; that cycle must not alter the results.
- sl=0 mid-division:
  - State frozen, cnt held. Division resumes when sl returns; not an error.
- Latency (ld at edge E0; controller holds sl from the cycle after E0):
  - Normal division: WIDTH step edges, f_done high after edge E0+WIDTH.
  - Divide by zero: f_done high after edge E0+1.
- Outputs:
  - quotient = quo; remainder = rem[W-1:0].
  - Stable from f_done until the next ld or reset.
- Reset mid-operation:
  - Immediately clears everything and asserts no f_done.
  - A later ld starts a clean division.
- Simultaneous ld and sl: ld wins, and no step is taken on that edge.

Decomposition:
- Shared package div_f_para.v: WIDTH and WIDTH_LOG_2 (existing); add `DIV_CNT_W.
- Sub-module div_step (combinational):
  - Inputs: rem, quo_msb, dvsr.
  - Outputs: next rem and the quotient bit.
  - Lets a later radix-4 variant instantiate two steps per cycle.

Test Plan (WIDTH=8):
- ld with init_val={8'd100, 8'd7}, then sl held high -> f_done pulses exactly 8 cycles after ld; quotient=14, remainder=2, div_by_zero=0; further sl leaves results unchanged.
- Operands {255, 1} -> quotient=255, remainder=0. Operands {5, 9} -> quotient=0, remainder=5. Each f_done is exactly one cycle wide.
- Operands {37, 0} -> f_done 1 cycle after ld; quotient=8'hFF, remainder=37, div_by_zero=1. The next ld of {37, 5} clears div_by_zero, giving quotient=7, remainder=2.
- Division {200, 3} with sl dropped for 3 cycles after step 4, then resumed -> f_done 11 cycles after ld; quotient=66, remainder=2.
- ld of {90, 4} with sl=1 in the same cycle, issued mid-way through {200, 3} -> restarts with no step on the ld edge; f_done 8 cycles later; quotient=22, remainder=2.
- rst driven low asynchronously between edges at step 5 -> outputs 0 immediately, with no f_done; after release, ld {9, 3} -> quotient=3, remainder=0.

Source files
------------

// File: rtl/div_shift_core_pkg.sv
// Shared sizing for the shift/subtract divider datapath.
// Widths default to the 32-bit build; the counter holds the value WIDTH.
package div_shift_core_pkg;
  localparam int DIV_WIDTH       = 32;
  localparam int DIV_WIDTH_LOG_2 = 5;
  localparam int DIV_CNT_W       = DIV_WIDTH_LOG_2 + 1;
endpackage

// File: rtl/div_shift_core_if.sv
// Controller <-> datapath handshake: ld/sl strobes in, results and f_done out.
interface div_shift_core_if
  import div_shift_core_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic               ld;
  logic               sl;
  logic [2*WIDTH-1:0] init_val;
  logic               f_done;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;

  modport master (
    output ld, sl, init_val,
    input  f_done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  ld, sl, init_val,
    output f_done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_shift_core_step.sv
// One restoring-division iteration: shift in the next dividend bit and try
// to subtract the divisor. Kept separate so a radix-4 core can chain two.
module div_step
  import div_shift_core_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted  = {rem, quo_msb};
  assign trial    = shifted - {1'b0, dvsr};
  // A clear borrow bit means the divisor fit: keep the difference.
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial : shifted;
endmodule

// File: rtl/div_shift_core.sv
// Radix-2 restoring divider datapath driven by the divider controller's
// ld/sl strobes; one quotient bit per sl cycle, f_done pulses on completion.
module div_shift_core
  import div_shift_core_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  div_shift_core_if.slave bus
);
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic             f_done_reg;
  logic             dz_reg;

  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic [WIDTH:0]   rem_next;
  logic             q_bit_next;
  logic             last_step;

  assign dividend_in = bus.init_val[2*WIDTH-1:WIDTH];
  assign divisor_in  = bus.init_val[WIDTH-1:0];
  assign last_step   = (cnt_reg == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg[WIDTH-1:0]),
    .quo_msb  (quo_reg[WIDTH-1]),
    .dvsr     (dvsr_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvsr_reg   <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      f_done_reg <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      f_done_reg <= 1'b0;
      if (bus.ld) begin
        quo_reg  <= dividend_in;
        rem_reg  <= '0;
        dvsr_reg <= divisor_in;
        cnt_reg  <= '0;
        done_reg <= 1'b0;
        dz_reg   <= (divisor_in == '0);
      end else if (bus.sl && !done_reg) begin
        if (dz_reg) begin
          // quo still holds the untouched dividend here.
          quo_reg    <= '1;
          rem_reg    <= {1'b0, quo_reg};
          done_reg   <= 1'b1;
          f_done_reg <= 1'b1;
        end else begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[WIDTH-2:0], q_bit_next};
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_step) begin
            done_reg   <= 1'b1;
            f_done_reg <= 1'b1;
          end
        end
      end
    end
  end

  // The partial remainder is always below the divisor, so its top bit never reaches the outputs.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_reg[WIDTH];

  assign bus.f_done      = f_done_reg;
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg[WIDTH-1:0];
  assign bus.div_by_zero = dz_reg;
endmodule

// File: tb/tb_div_shift_core.sv
// Bench for div_shift_core at WIDTH=8: table-driven divisions plus pause,
// mid-division reload and async-reset sequences, checked via a scoreboard.
module tb_div_shift_core;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_shift_core_if #(.WIDTH(W)) bus ();

  div_shift_core #(.WIDTH(W), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive ld for one edge (E0); returns at the negedge just after E0 with sl=1.
  task automatic issue_ld(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sl_same);
    @(negedge clk);
    bus.ld       = 1'b1;
    bus.init_val = {dd, dv};
    bus.sl       = sl_same;
    @(negedge clk);
    bus.ld = 1'b0;
    bus.sl = 1'b1;
    chk("no_fdone_on_ld", int'(bus.f_done), 0);
  endtask

  // Wait (bounded) for f_done, optionally dropping sl for pause_len cycles after pause_after steps.
  task automatic await_done(input string tag, input int pause_after, input int pause_len);
    exp_t e;
    int   k;
    int   lat;
    bit   got;
    got = 1'b0;
    lat = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.f_done) begin
        got = 1'b1;
        lat = k;
        break;
      end
      if (k == pause_after) bus.sl = 1'b0;
      if (k == pause_after + pause_len) bus.sl = 1'b1;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_quotient"}, int'(bus.quotient), int'(e.q));
      chk({tag, "_remainder"}, int'(bus.remainder), int'(e.r));
      chk({tag, "_dz"}, int'(bus.div_by_zero), int'(e.dz));
      $display("TXN %s: q=%0d r=%0d dz=%0d latency=%0d", tag, bus.quotient,
               bus.remainder, bus.div_by_zero, lat);
      // sl still high: results must hold and the pulse must end.
      @(negedge clk);
      chk({tag, "_fdone_width"}, int'(bus.f_done), 0);
      chk({tag, "_q_hold"}, int'(bus.quotient), int'(e.q));
      chk({tag, "_r_hold"}, int'(bus.remainder), int'(e.r));
    end
    bus.sl = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    bit saw;
    vecs[0] = '{dd: 8'd100, dv: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0, lat: 8};
    vecs[1] = '{dd: 8'd255, dv: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 8};
    vecs[2] = '{dd: 8'd5,   dv: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: 8};
    vecs[3] = '{dd: 8'd37,  dv: 8'd0,   q: 8'hFF,  r: 8'd37, dz: 1'b1, lat: 1};
    vecs[4] = '{dd: 8'd37,  dv: 8'd5,   q: 8'd7,   r: 8'd2,  dz: 1'b0, lat: 8};
    vecs[5] = '{dd: 8'd0,   dv: 8'd5,   q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: 8};
    vecs[6] = '{dd: 8'd255, dv: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0, lat: 8};
    vecs[7] = '{dd: 8'd128, dv: 8'd16,  q: 8'd8,   r: 8'd0,  dz: 1'b0, lat: 8};
    vecs[8] = '{dd: 8'd250, dv: 8'd17,  q: 8'd14,  r: 8'd12, dz: 1'b0, lat: 8};

    bus.ld       = 1'b0;
    bus.sl       = 1'b0;
    bus.init_val = '0;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", int'(bus.quotient), 0);
    chk("reset_remainder", int'(bus.remainder), 0);
    chk("reset_dz", int'(bus.div_by_zero), 0);
    chk("reset_fdone", int'(bus.f_done), 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      sb.push_back('{q: vecs[i].q, r: vecs[i].r, dz: vecs[i].dz, lat: vecs[i].lat});
      issue_ld(vecs[i].dd, vecs[i].dv, 1'b0);
      await_done($sformatf("vec%0d_%0d_div_%0d", i, vecs[i].dd, vecs[i].dv), 100, 0);
    end

    // sl dropped for 3 cycles after step 4.
    sb.push_back('{q: 8'd66, r: 8'd2, dz: 1'b0, lat: 11});
    issue_ld(8'd200, 8'd3, 1'b0);
    await_done("pause_200_div_3", 4, 3);

    // Reload with sl=1 mid-way through another division.
    issue_ld(8'd200, 8'd3, 1'b0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.f_done) saw = 1'b1;
    end
    chk("abort_no_fdone", int'(saw), 0);
    sb.push_back('{q: 8'd22, r: 8'd2, dz: 1'b0, lat: 8});
    issue_ld(8'd90, 8'd4, 1'b1);
    await_done("reload_90_div_4", 100, 0);

    // Asynchronous reset between edges after step 5.
    issue_ld(8'd100, 8'd7, 1'b0);
    repeat (5) @(negedge clk);
    chk("prereset_busy", int'(bus.quotient != 8'd0), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_quotient", int'(bus.quotient), 0);
    chk("async_rst_remainder", int'(bus.remainder), 0);
    chk("async_rst_fdone", int'(bus.f_done), 0);
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.f_done) saw = 1'b1;
    end
    chk("rst_no_fdone", int'(saw), 0);
    bus.sl = 1'b0;
    rst    = 1'b1;
    sb.push_back('{q: 8'd3, r: 8'd0, dz: 1'b0, lat: 8});
    issue_ld(8'd9, 8'd3, 1'b0);
    await_done("post_rst_9_div_3", 100, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
